// File: rtl/alu_control_fsm_if.sv
// Issue/control bundle between the multicycle sequencer (master) and the datapath it steers (slave).
interface alu_control_fsm_if #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_W     = 16
);
    logic                 inst_valid;
    logic                 inst_ready;
    logic [WORD_SIZE-1:0] inst;
    logic                 mem_done;
    logic                 alu_b_result;
    logic [3:0]           alu_func;
    logic                 alu_a_sel;
    logic [1:0]           alu_b_sel;
    logic                 pc_write;
    logic [1:0]           pc_src;
    logic                 reg_write;
    logic [1:0]           reg_dst;
    logic                 mem_read;
    logic                 mem_write;
    logic                 wwd_valid;
    logic                 halted;
    logic [CNT_W-1:0]     num_inst;

    modport master (
        input  inst_valid, inst, mem_done, alu_b_result,
        output inst_ready, alu_func, alu_a_sel, alu_b_sel, pc_write, pc_src,
               reg_write, reg_dst, mem_read, mem_write, wwd_valid, halted, num_inst
    );

    modport slave (
        output inst_valid, inst, mem_done, alu_b_result,
        input  inst_ready, alu_func, alu_a_sel, alu_b_sel, pc_write, pc_src,
               reg_write, reg_dst, mem_read, mem_write, wwd_valid, halted, num_inst
    );
endinterface

// File: rtl/alu_control_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the 16-bit ALU, PC, register file and memory.
// Define ALU_CTRL_ILLEGAL_EN to add the sticky illegal_inst port; otherwise undefined opcodes retire as NOPs.
module alu_control_fsm #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic reset_n,
    alu_control_fsm_if.master bus
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    output logic illegal_inst
`endif
);
    // ALU funcCode encodings
    localparam logic [3:0] FUNC_ADD = 4'd0, FUNC_ORR = 4'd3, FUNC_LHI = 4'd8,
                           FUNC_BNE = 4'd9, FUNC_BEQ = 4'd10, FUNC_BGZ = 4'd11,
                           FUNC_BLZ = 4'd12, FUNC_JMP = 4'd13;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [3:0] {C_RALU, C_ADI, C_ORI, C_LHI, C_BR, C_JMP, C_JAL, C_JPR,
                              C_JRL, C_LWD, C_SWD, C_WWD, C_HLT, C_ILL} cls_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] inst_q;
    logic [CNT_W-1:0]     num_q;
    logic                 retire;
    cls_t                 cls;
    logic [3:0]           op;
    logic [5:0]           func;
    logic                 unused_fields;

    logic       ready_c, a_sel_c, pc_write_c, reg_write_c;
    logic       mem_read_c, mem_write_c, wwd_c, halted_c;
    logic [3:0] func_c;
    logic [1:0] b_sel_c, pc_src_c, reg_dst_c;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic       ill_set, illegal_q;
`endif

    assign op            = inst_q[15:12];
    assign func          = inst_q[5:0];
    assign unused_fields = ^inst_q[11:6];

    always_comb begin
        cls = C_ILL;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: cls = C_BR;
            4'd4:  cls = C_ADI;
            4'd5:  cls = C_ORI;
            4'd6:  cls = C_LHI;
            4'd7:  cls = C_LWD;
            4'd8:  cls = C_SWD;
            4'd9:  cls = C_JMP;
            4'd10: cls = C_JAL;
            4'd15: begin
                if (func <= 6'd7) cls = C_RALU;
                else if (func == 6'd25) cls = C_JPR;
                else if (func == 6'd26) cls = C_JRL;
                else if (func == 6'd28) cls = C_WWD;
                else if (func == 6'd29) cls = C_HLT;
                else cls = C_ILL;
            end
            default: cls = C_ILL;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        ready_c     = 1'b0;
        func_c      = 4'd0;
        a_sel_c     = 1'b0;
        b_sel_c     = 2'd0;
        pc_write_c  = 1'b0;
        pc_src_c    = 2'd0;
        reg_write_c = 1'b0;
        reg_dst_c   = 2'd0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        wwd_c       = 1'b0;
        halted_c    = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_EN
        ill_set     = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                ready_c = 1'b1;
                if (bus.inst_valid) state_d = DECODE;
            end
            DECODE: begin
                // PC+1 is computed for every instruction, including undefined ones
                func_c     = FUNC_ADD;
                b_sel_c    = 2'd3;
                pc_write_c = 1'b1;
                state_d    = EXEC;
`ifdef ALU_CTRL_ILLEGAL_EN
                if (cls == C_ILL) begin
                    ill_set = 1'b1;
                    state_d = HALT;
                end
`endif
            end
            EXEC: begin
                state_d = FETCH;
                retire  = 1'b1;
                case (cls)
                    C_RALU: begin
                        func_c = func[3:0]; a_sel_c = 1'b1; state_d = WB; retire = 1'b0;
                    end
                    C_ADI: begin
                        func_c = FUNC_ADD; a_sel_c = 1'b1; b_sel_c = 2'd1; state_d = WB; retire = 1'b0;
                    end
                    C_ORI: begin
                        func_c = FUNC_ORR; a_sel_c = 1'b1; b_sel_c = 2'd2; state_d = WB; retire = 1'b0;
                    end
                    C_LHI: begin
                        func_c = FUNC_LHI; a_sel_c = 1'b1; b_sel_c = 2'd2; state_d = WB; retire = 1'b0;
                    end
                    C_BR: begin
                        case (op[1:0])
                            2'd0:    func_c = FUNC_BNE;
                            2'd1:    func_c = FUNC_BEQ;
                            2'd2:    func_c = FUNC_BGZ;
                            default: func_c = FUNC_BLZ;
                        endcase
                        a_sel_c = 1'b1;
                        // Branch flag comes back combinationally from the ALU in this same cycle
                        pc_write_c = bus.alu_b_result;
                        pc_src_c   = bus.alu_b_result ? 2'd1 : 2'd0;
                    end
                    C_JMP, C_JAL: begin
                        func_c = FUNC_JMP; b_sel_c = 2'd2; pc_write_c = 1'b1; pc_src_c = 2'd2;
                        if (cls == C_JAL) begin
                            state_d = WB; retire = 1'b0;
                        end
                    end
                    C_JPR, C_JRL: begin
                        a_sel_c = 1'b1; pc_write_c = 1'b1; pc_src_c = 2'd3;
                        if (cls == C_JRL) begin
                            state_d = WB; retire = 1'b0;
                        end
                    end
                    C_LWD, C_SWD: begin
                        func_c = FUNC_ADD; a_sel_c = 1'b1; b_sel_c = 2'd1; state_d = MEM; retire = 1'b0;
                    end
                    C_WWD: begin
                        a_sel_c = 1'b1; wwd_c = 1'b1;
                    end
                    C_HLT: begin
                        halted_c = 1'b1; state_d = HALT;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                mem_read_c  = (cls == C_LWD);
                mem_write_c = (cls == C_SWD);
                if (bus.mem_done) begin
                    if (cls == C_LWD) begin
                        state_d = WB;
                    end else begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            WB: begin
                reg_write_c = 1'b1;
                if (cls == C_RALU) reg_dst_c = 2'd1;
                else if (cls == C_JAL || cls == C_JRL) reg_dst_c = 2'd2;
                else reg_dst_c = 2'd0;
                state_d = FETCH;
                retire  = 1'b1;
            end
            HALT: halted_c = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) num_q <= num_q + CNT_W'(1);
        end
    end

    // Instruction word is datapath state and needs no reset
    always_ff @(posedge clk) begin
        if (state_q == FETCH && bus.inst_valid) inst_q <= bus.inst;
    end

`ifdef ALU_CTRL_ILLEGAL_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     illegal_q <= 1'b0;
        else if (ill_set) illegal_q <= 1'b1;
    end
    assign illegal_inst = illegal_q;
`endif

    // FETCH is the reset state, so ready is masked to keep all outputs low while reset is held
    assign bus.inst_ready = ready_c & reset_n;
    assign bus.alu_func   = func_c;
    assign bus.alu_a_sel  = a_sel_c;
    assign bus.alu_b_sel  = b_sel_c;
    assign bus.pc_write   = pc_write_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.reg_write  = reg_write_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.wwd_valid  = wwd_c;
    assign bus.halted     = halted_c;
    assign bus.num_inst   = num_q;
endmodule

// File: tb/tb_alu_control_fsm.sv
// Directed bench for alu_control_fsm: hand-computed per-cycle control outputs for each instruction class.
`timescale 1ns/1ps
module tb_alu_control_fsm;
    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic illegal_inst;
`endif

    alu_control_fsm_if #(.WORD_SIZE(16), .CNT_W(16)) bus ();

    alu_control_fsm #(.WORD_SIZE(16), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef ALU_CTRL_ILLEGAL_EN
        ,
        .illegal_inst (illegal_inst)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2ns after the rising edge; outputs are checked 1ns later
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [15:0] w);
        bus.inst       = w;
        bus.inst_valid = 1'b1;
        settle();
        check_eq("fetch_ready", bus.inst_ready, 1);
        tick();
        bus.inst_valid = 1'b0;
        settle();
        check_eq("dec_func", bus.alu_func, 0);
        check_eq("dec_bsel", bus.alu_b_sel, 3);
        check_eq("dec_pcw", bus.pc_write, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        settle();
        check_eq("rst_ready", bus.inst_ready, 0);
        check_eq("rst_num", bus.num_inst, 0);
        check_eq("rst_halted", bus.halted, 0);
        tick();
        reset_n = 1'b1;
        settle();
        check_eq("post_rst_ready", bus.inst_ready, 1);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.inst_valid   = 1'b0;
        bus.inst         = 16'h0000;
        bus.mem_done     = 1'b0;
        bus.alu_b_result = 1'b0;
        #2;
        do_reset();

        // T2: ADD $1,$2,$3
        issue(16'hF6C0);
        check_eq("add_dec_asel", bus.alu_a_sel, 0);
        check_eq("add_dec_pcsrc", bus.pc_src, 0);
        tick(); settle();
        check_eq("add_ex_func", bus.alu_func, 0);
        check_eq("add_ex_asel", bus.alu_a_sel, 1);
        check_eq("add_ex_bsel", bus.alu_b_sel, 0);
        check_eq("add_ex_pcw", bus.pc_write, 0);
        check_eq("add_ex_regw", bus.reg_write, 0);
        tick(); settle();
        check_eq("add_wb_regw", bus.reg_write, 1);
        check_eq("add_wb_dst", bus.reg_dst, 1);
        check_eq("add_wb_func", bus.alu_func, 0);
        tick(); settle();
        check_eq("add_num", bus.num_inst, 1);
        check_eq("add_ready", bus.inst_ready, 1);
        check_eq("add_regw_off", bus.reg_write, 0);

        // T1: reset dropped mid-EXEC
        issue(16'hF6C0);
        tick(); settle();
        check_eq("t1_ex_asel", bus.alu_a_sel, 1);
        reset_n = 1'b0;
        settle();
        check_eq("t1_asel_0", bus.alu_a_sel, 0);
        check_eq("t1_ready_0", bus.inst_ready, 0);
        check_eq("t1_num_0", bus.num_inst, 0);
        tick();
        reset_n = 1'b1;
        settle();
        check_eq("t1_fetch", bus.inst_ready, 1);
        tick(); settle();
        check_eq("t1_no_wb", bus.reg_write, 0);
        check_eq("t1_num_hold", bus.num_inst, 0);

        // T3: BEQ taken
        issue(16'h1405);
        tick();
        bus.alu_b_result = 1'b1;
        settle();
        check_eq("beq_t_func", bus.alu_func, 10);
        check_eq("beq_t_asel", bus.alu_a_sel, 1);
        check_eq("beq_t_pcw", bus.pc_write, 1);
        check_eq("beq_t_pcsrc", bus.pc_src, 1);
        tick();
        bus.alu_b_result = 1'b0;
        settle();
        check_eq("beq_t_num", bus.num_inst, 1);
        check_eq("beq_t_ready", bus.inst_ready, 1);
        // BEQ not taken
        issue(16'h1405);
        tick(); settle();
        check_eq("beq_n_func", bus.alu_func, 10);
        check_eq("beq_n_pcw", bus.pc_write, 0);
        tick(); settle();
        check_eq("beq_n_num", bus.num_inst, 2);
        check_eq("beq_n_ready", bus.inst_ready, 1);

        // T4: LWD with mem_done on the second MEM cycle
        issue(16'h7605);
        tick(); settle();
        check_eq("lwd_ex_func", bus.alu_func, 0);
        check_eq("lwd_ex_asel", bus.alu_a_sel, 1);
        check_eq("lwd_ex_bsel", bus.alu_b_sel, 1);
        check_eq("lwd_ex_rd", bus.mem_read, 0);
        tick(); settle();
        check_eq("lwd_mem1_rd", bus.mem_read, 1);
        check_eq("lwd_mem1_func", bus.alu_func, 0);
        tick();
        bus.mem_done = 1'b1;
        settle();
        check_eq("lwd_mem2_rd", bus.mem_read, 1);
        tick();
        bus.mem_done = 1'b0;
        settle();
        check_eq("lwd_wb_rd", bus.mem_read, 0);
        check_eq("lwd_wb_regw", bus.reg_write, 1);
        check_eq("lwd_wb_dst", bus.reg_dst, 0);
        tick(); settle();
        check_eq("lwd_num", bus.num_inst, 3);
        check_eq("lwd_ready", bus.inst_ready, 1);

        // SWD with immediate mem_done
        issue(16'h8605);
        tick(); tick();
        bus.mem_done = 1'b1;
        settle();
        check_eq("swd_mem_wr", bus.mem_write, 1);
        check_eq("swd_mem_rd", bus.mem_read, 0);
        tick();
        bus.mem_done = 1'b0;
        settle();
        check_eq("swd_wr_off", bus.mem_write, 0);
        check_eq("swd_no_regw", bus.reg_write, 0);
        check_eq("swd_num", bus.num_inst, 4);

        // ORI
        issue(16'h5605);
        tick(); settle();
        check_eq("ori_func", bus.alu_func, 3);
        check_eq("ori_bsel", bus.alu_b_sel, 2);
        tick(); settle();
        check_eq("ori_wb_regw", bus.reg_write, 1);
        check_eq("ori_wb_dst", bus.reg_dst, 0);
        tick(); settle();
        check_eq("ori_num", bus.num_inst, 5);

        // WWD
        issue(16'hF01C);
        tick(); settle();
        check_eq("wwd_valid", bus.wwd_valid, 1);
        tick(); settle();
        check_eq("wwd_off", bus.wwd_valid, 0);
        check_eq("wwd_num", bus.num_inst, 6);

        // T5: JAL then HLT from a fresh reset
        tick();
        do_reset();
        issue(16'hA123);
        tick(); settle();
        check_eq("jal_func", bus.alu_func, 13);
        check_eq("jal_asel", bus.alu_a_sel, 0);
        check_eq("jal_bsel", bus.alu_b_sel, 2);
        check_eq("jal_pcw", bus.pc_write, 1);
        check_eq("jal_pcsrc", bus.pc_src, 2);
        tick(); settle();
        check_eq("jal_wb_regw", bus.reg_write, 1);
        check_eq("jal_wb_dst", bus.reg_dst, 2);
        check_eq("jal_wb_pcw", bus.pc_write, 0);
        tick(); settle();
        check_eq("jal_num", bus.num_inst, 1);
        issue(16'hF01D);
        tick(); settle();
        check_eq("hlt_ex_halted", bus.halted, 1);
        bus.inst_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(); settle();
            check_eq("hlt_halted", bus.halted, 1);
            check_eq("hlt_ready", bus.inst_ready, 0);
        end
        bus.inst_valid = 1'b0;
        check_eq("hlt_num", bus.num_inst, 2);
        check_eq("hlt_func", bus.alu_func, 0);

        // T6: undefined opcode
        tick();
        do_reset();
        issue(16'hB000);
`ifdef ALU_CTRL_ILLEGAL_EN
        tick(); settle();
        check_eq("ill_flag", illegal_inst, 1);
        check_eq("ill_halted", bus.halted, 1);
        check_eq("ill_ready", bus.inst_ready, 0);
        check_eq("ill_num", bus.num_inst, 0);
`else
        tick(); settle();
        check_eq("nop_regw", bus.reg_write, 0);
        check_eq("nop_pcw", bus.pc_write, 0);
        tick(); settle();
        check_eq("nop_num", bus.num_inst, 1);
        check_eq("nop_ready", bus.inst_ready, 1);
        check_eq("nop_regw2", bus.reg_write, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
